stepper_positioner: RTL

- Parametrised successor to the 8-state half-step stepper sequencer.
- Accepts a move command (absolute target, step mode, step period) over a valid/ready handshake.
- Generates step timing internally, drives the 4 coil outputs, tracks signed absolute position, and reports busy/done.
- Sits between the motion-command logic and the coil driver pins.

---
 rtl/stepper_positioner.sv | 96 +++++++++
 1 files changed

// File: rtl/stepper_positioner.sv
// stepper_positioner: move-to-target half-step stepper sequencer with step timing and position tracking
// Ports: clock/reset (async, active-high); cmd_valid/cmd_ready handshake with cmd_target (signed half-steps),
// cmd_mode (00 wave, 01 full, 1x half), cmd_period (cycles per step, 0 acts as 1); abort stops a move;
// drive = coil outputs, position = signed current position, busy = move in progress, done = completion pulse.
// Option: define STEPPER_IDLE_RELEASE_EN to de-energise the coils (drive=0000) whenever not busy.
module stepper_positioner #(
    parameter int POS_W = 16,
    parameter int DIV_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [POS_W-1:0] cmd_target,
    input  logic [1:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_period,
    input  logic             abort,
    output logic [3:0]       drive,
    output logic [POS_W-1:0] position,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    // SEQ[i] lives at bits [4*i +: 4]
    localparam logic [31:0] SEQ = {4'b0011, 4'b0010, 4'b1010, 4'b1000, 4'b1100, 4'b0100, 4'b0101, 4'b0001};
    state_t state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d, tgt_q, tgt_d, tgt_f, step;
    logic [1:0] mode_q, mode_d;
    logic [DIV_W-1:0] rld_q, rld_d, cnt_q, cnt_d;
    logic done_q, done_d;
    logic [3:0] seq_out;
    // wave targets land on even positions, full on odd ones
    assign tgt_f = {cmd_target[POS_W-1:1], cmd_mode == 2'b00 ? 1'b0 : cmd_mode == 2'b01 ? 1'b1 : cmd_target[0]};
    // single half-step in half mode or while realigning to the mode's parity
    assign step = (mode_q[1] || (pos_q[0] ^ mode_q[0])) ? POS_W'(1) : POS_W'(2);
    always_comb begin
        state_d = state_q;
        pos_d = pos_q;
        tgt_d = tgt_q;
        mode_d = mode_q;
        rld_d = rld_q;
        cnt_d = cnt_q;
        done_d = 1'b0;
        if (state_q == IDLE) begin
            if (cmd_valid) begin
                tgt_d = tgt_f;
                mode_d = cmd_mode;
                rld_d = cmd_period == '0 ? '0 : cmd_period - DIV_W'(1);
                cnt_d = rld_d;
                done_d = tgt_f == pos_q;
                state_d = tgt_f == pos_q ? IDLE : RUN;
            end
        end else if (abort) begin
            state_d = IDLE;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DIV_W'(1);
        end else begin
            cnt_d = rld_q;
            // signed distance picks the shorter way round the wrap
            pos_d = $signed(tgt_q - pos_q) < 0 ? pos_q - step : pos_q + step;
            if (pos_d == tgt_q) begin
                state_d = IDLE;
                done_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pos_q <= '0;
            tgt_q <= '0;
            mode_q <= '0;
            rld_q <= '0;
            cnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q <= pos_d;
            tgt_q <= tgt_d;
            mode_q <= mode_d;
            rld_q <= rld_d;
            cnt_q <= cnt_d;
            done_q <= done_d;
        end
    end
    assign busy = state_q == RUN;
    assign cmd_ready = ~busy;
    assign done = done_q;
    assign position = pos_q;
    assign seq_out = SEQ[{pos_q[2:0], 2'b00} +: 4];
`ifdef STEPPER_IDLE_RELEASE_EN
    assign drive = busy ? seq_out : 4'b0000;
`else
    assign drive = seq_out;
`endif
endmodule
